wb_master_ctrl: RTL and testbench

- Wishbone classic (B4, non-pipelined) single-transfer master.
- It is the initiator counterpart to the user-area Wishbone slave port. It turns a simple valid/ready command into one bus cycle and returns the read data and a status through a valid/ready response channel.
- It lets user logic (LA-driven sequencers, test engines) drive slaves that follow the wbs_* conventions.
- It handles one outstanding transfer at a time, with a bus timeout.

---
 rtl/wb_master_pkg.sv | 28 ++
 rtl/wb_master_ctrl_if.sv | 66 ++++++
 rtl/wb_timeout_cnt.sv | 51 +++++
 rtl/wb_master_ctrl.sv | 135 +++++++++++++
 tb/tb_wb_master_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_pkg
// Shared types and helpers for the Wishbone classic single-transfer master.
//   state_e       : controller state (IDLE -> BUS -> RESP -> IDLE)
//   ST_*          : response status codes carried on rsp_status_o
//   cnt_width()   : bit width of the bus timeout counter
// -----------------------------------------------------------------------------
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  // The counter has to hold TIMEOUT_CYCLES itself (its saturation value), so
  // it needs clog2(cycles+1) bits; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl_if
// Bundles the command channel, response channel, status and Wishbone master
// bus of wb_master_ctrl.
//   master modport : the controller's view (drives cmd_ready_o, rsp_*, busy_o,
//                    wbm_cyc/stb/we/sel/adr/dat_o)
//   slave modport  : the environment's view (user logic plus Wishbone slave)
//
// Handshake rule for both cmd_* and rsp_* channels: a transfer happens on a
// rising clock edge where valid && ready are both high. Once valid is raised
// the payload stays stable until that edge; ready may be high without valid.
// -----------------------------------------------------------------------------
interface wb_master_ctrl_if #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
);
  localparam int SEL_W = DAT_W / 8;

  // command channel
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_we_i;
  logic [SEL_W-1:0] cmd_sel_i;
  logic [ADR_W-1:0] cmd_adr_i;
  logic [DAT_W-1:0] cmd_dat_i;

  // response channel
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [DAT_W-1:0] rsp_dat_o;
  logic [1:0]       rsp_status_o;

  logic             busy_o;

  // Wishbone master bus
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o;
  logic             wbm_ack_i;
  logic             wbm_err_i;
  logic [DAT_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    input  rsp_ready_i,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    output busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    output rsp_ready_i,
    output wbm_ack_i, wbm_err_i, wbm_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter that flags the last permitted bus cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (held while the controller is idle)
//   enable     : count this cycle (bus cycle without ack/err)
//   expired    : counter sits at TIMEOUT_CYCLES-1, i.e. the current bus cycle
//                is the last one allowed
// TIMEOUT_CYCLES = 0 removes the counter and ties expired low.
// -----------------------------------------------------------------------------
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n ^ clear ^ enable;
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt;

      // Saturates at TIMEOUT_CYCLES so a stalled enable can never wrap back
      // through LAST and re-fire.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && (cnt != SAT)) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl
// Wishbone classic (B4, non-pipelined) single-transfer master. One command in,
// one bus cycle out, one response back; a single transfer in flight.
//   wb_clk_i    : clock
//   wb_rstn_i   : asynchronous active-low reset
//   bus         : wb_master_ctrl_if.master (cmd channel, rsp channel, busy,
//                 Wishbone master signals)
//   dbg_state_o : current controller state
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  wb_master_ctrl_if.master bus,
  output state_e           dbg_state_o
);

  localparam int SEL_W = DAT_W / 8;

  state_e           state;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic             cyc_q;
  logic             we_q;
  logic [SEL_W-1:0] sel_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] wdat_q;
  logic [DAT_W-1:0] rdat_q;
  logic [1:0]       status_q;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  assign cnt_clear  = (state == IDLE);
  assign cnt_enable = (state == BUS) && !bus.wbm_ack_i && !bus.wbm_err_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (wb_clk_i),
    .rst_n   (wb_rstn_i),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      status_q    <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready_q && bus.cmd_valid_i) begin
            we_q        <= bus.cmd_we_i;
            sel_q       <= bus.cmd_sel_i;
            adr_q       <= bus.cmd_adr_i;
            wdat_q      <= bus.cmd_dat_i;
            cyc_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= BUS;
          end else begin
            // Also raises ready on the first edge after reset release.
            cmd_ready_q <= 1'b1;
          end
        end

        BUS: begin
          // err beats ack, and either beats an expiring timeout.
          if (bus.wbm_err_i || bus.wbm_ack_i || cnt_expired) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
            if (bus.wbm_err_i) begin
              status_q <= ST_ERR;
              rdat_q   <= '0;
            end else if (bus.wbm_ack_i) begin
              status_q <= ST_OK;
              rdat_q   <= we_q ? '0 : bus.wbm_dat_i;
            end else begin
              status_q <= ST_TIMEOUT;
              rdat_q   <= '0;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rdat_q;
  assign bus.rsp_status_o = status_q;
  assign bus.busy_o       = busy_q;
  assign bus.wbm_cyc_o    = cyc_q;
  assign bus.wbm_stb_o    = cyc_q;
  assign bus.wbm_we_o     = we_q;
  assign bus.wbm_sel_o    = sel_q;
  assign bus.wbm_adr_o    = adr_q;
  assign bus.wbm_dat_o    = wdat_q;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_master_ctrl
// Self-checking bench for wb_master_ctrl (TIMEOUT_CYCLES = 8). Inputs change
// 1 time unit after the rising edge; outputs are read there or on the falling
// edge. Expected responses {status, data} are queued when a command is driven
// and popped by the response monitor on each rsp handshake.
// -----------------------------------------------------------------------------
module tb_wb_master_ctrl;
  import wb_master_pkg::*;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int TMO   = 8;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  wb_master_ctrl_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) wif ();
  state_e dbg_state;

  wb_master_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .ADR_W(ADR_W),
    .DAT_W(DAT_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .bus         (wif.master),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [33:0] mon_got;
  logic [33:0] mon_exp;

  always @(negedge clk) begin
    if (rstn && wif.rsp_valid_o && wif.rsp_ready_i) begin
      mon_got = {wif.rsp_status_o, wif.rsp_dat_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got status=%0d dat=%h, required no response", mon_got[33:32], mon_got[31:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL rsp_data: got status=%0d dat=%h, required status=%0d dat=%h", mon_got[33:32], mon_got[31:0], mon_exp[33:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wif.cmd_valid_i = 1'b0;
    wif.cmd_we_i    = 1'b0;
    wif.cmd_sel_i   = '0;
    wif.cmd_adr_i   = '0;
    wif.cmd_dat_i   = '0;
    wif.rsp_ready_i = 1'b1;
    wif.wbm_ack_i   = 1'b0;
    wif.wbm_err_i   = 1'b0;
    wif.wbm_dat_i   = '0;
  endtask

  // Presents a command and returns just after the accepting edge.
  task automatic send_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, output int accept_cycle);
    int guard;
    guard = 0;
    wif.cmd_we_i    = we;
    wif.cmd_sel_i   = sel;
    wif.cmd_adr_i   = adr;
    wif.cmd_dat_i   = dat;
    wif.cmd_valid_i = 1'b1;
    while (wif.cmd_ready_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1 within 20 cycles", wif.cmd_ready_o);
    end
    tick();
    accept_cycle    = cycle_n;
    wif.cmd_valid_i = 1'b0;
    wif.cmd_dat_i   = $urandom;
    wif.cmd_adr_i   = $urandom;
  endtask

  // Slave model: answers in bus cycle wait_n (0-based); wait_n < 0 never answers.
  task automatic slave_reply(input int wait_n, input logic do_ack, input logic do_err,
                             input logic [31:0] rdata, output int cyc_n, output logic stable);
    logic [31:0] adr0;
    logic [31:0] dat0;
    logic [3:0]  sel0;
    logic        we0;
    cyc_n  = 0;
    stable = 1'b1;
    adr0   = wif.wbm_adr_o;
    dat0   = wif.wbm_dat_o;
    sel0   = wif.wbm_sel_o;
    we0    = wif.wbm_we_o;
    for (int k = 0; k < 40; k++) begin
      if (wif.wbm_cyc_o !== 1'b1) break;
      cyc_n++;
      if (wif.wbm_stb_o !== 1'b1 || wif.wbm_adr_o !== adr0 || wif.wbm_dat_o !== dat0 ||
          wif.wbm_sel_o !== sel0 || wif.wbm_we_o !== we0)
        stable = 1'b0;
      if (k == wait_n) begin
        wif.wbm_ack_i = do_ack;
        wif.wbm_err_i = do_err;
        wif.wbm_dat_i = rdata;
      end else begin
        wif.wbm_ack_i = 1'b0;
        wif.wbm_err_i = 1'b0;
        wif.wbm_dat_i = $urandom;
      end
      tick();
    end
    wif.wbm_ack_i = 1'b0;
    wif.wbm_err_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [106:0] outs;
    idle_inputs();
    rstn = 1'b0;
    #2;
    total++;
    if (wif.cmd_ready_o !== 1'b0 || wif.wbm_cyc_o !== 1'b0 || wif.wbm_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: ready=%b cyc=%b stb=%b, required 0 0 0", wif.cmd_ready_o, wif.wbm_cyc_o, wif.wbm_stb_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {wif.cmd_ready_o, wif.rsp_valid_o, wif.rsp_dat_o, wif.rsp_status_o, wif.busy_o,
              wif.wbm_cyc_o, wif.wbm_stb_o, wif.wbm_we_o, wif.wbm_sel_o, wif.wbm_adr_o};
      total++;
      if (outs !== '0 || wif.wbm_dat_o !== '0) begin
        bad++;
        $display("FAIL reset_outputs: cycle %0d outs=%h wbm_dat=%h, required all 0", i, outs, wif.wbm_dat_o);
      end
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    total++;
    if (wif.cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_pre_edge: got %b, required 0", wif.cmd_ready_o);
    end
    tick();
    total++;
    if (wif.cmd_ready_o !== 1'b1 || dbg_state !== IDLE || wif.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_post_edge: ready=%b state=%0d busy=%b, required 1 0 0", wif.cmd_ready_o, dbg_state, wif.busy_o);
    end
  endtask

  task automatic test_write();
    int c;
    int n;
    logic st;
    exp_q.push_back({ST_OK, 32'h0});
    send_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, c);
    total++;
    if (wif.wbm_adr_o !== 32'h3000_0004 || wif.wbm_dat_o !== 32'hDEAD_BEEF ||
        wif.wbm_sel_o !== 4'hF || wif.wbm_we_o !== 1'b1 || wif.wbm_stb_o !== 1'b1 ||
        wif.cmd_ready_o !== 1'b0 || wif.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL write_bus_fields: adr=%h dat=%h sel=%h we=%b stb=%b ready=%b busy=%b, required 30000004 deadbeef f 1 1 0 1",
               wif.wbm_adr_o, wif.wbm_dat_o, wif.wbm_sel_o, wif.wbm_we_o, wif.wbm_stb_o, wif.cmd_ready_o, wif.busy_o);
    end
    slave_reply(2, 1'b1, 1'b0, 32'hA5A5_A5A5, n, st);
    total++;
    if (n !== 3 || st !== 1'b1) begin
      bad++;
      $display("FAIL write_cyc_len: cycles=%0d stable=%b, required 3 1", n, st);
    end
    total++;
    if (wif.rsp_valid_o !== 1'b1 || wif.rsp_status_o !== ST_OK || wif.rsp_dat_o !== 32'h0 || wif.wbm_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL write_rsp: valid=%b status=%0d dat=%h stb=%b, required 1 0 0 0", wif.rsp_valid_o, wif.rsp_status_o, wif.rsp_dat_o, wif.wbm_stb_o);
    end
    tick();
    tick();
  endtask

  task automatic test_read_hold();
    int c;
    int n;
    logic st;
    wif.rsp_ready_i = 1'b0;
    exp_q.push_back({ST_OK, 32'h1234_5678});
    send_cmd(1'b0, 4'hF, 32'h3000_0000, $urandom, c);
    slave_reply(0, 1'b1, 1'b0, 32'h1234_5678, n, st);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL read_cyc_len: cycles=%0d, required 1", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wif.rsp_valid_o !== 1'b1 || wif.rsp_dat_o !== 32'h1234_5678 || wif.rsp_status_o !== ST_OK ||
          wif.cmd_ready_o !== 1'b0 || dbg_state !== RESP) begin
        bad++;
        $display("FAIL read_hold: cycle %0d valid=%b dat=%h status=%0d ready=%b state=%0d, required 1 12345678 0 0 2",
                 i, wif.rsp_valid_o, wif.rsp_dat_o, wif.rsp_status_o, wif.cmd_ready_o, dbg_state);
      end
      tick();
    end
    wif.rsp_ready_i = 1'b1;
    tick();
    total++;
    if (wif.rsp_valid_o !== 1'b0 || wif.cmd_ready_o !== 1'b1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL read_release: valid=%b ready=%b state=%0d, required 0 1 0", wif.rsp_valid_o, wif.cmd_ready_o, dbg_state);
    end
  endtask

  task automatic test_error();
    int c;
    int n;
    logic st;
    exp_q.push_back({ST_ERR, 32'h0});
    send_cmd(1'b0, 4'h3, 32'h3000_0010, 32'h0, c);
    slave_reply(1, 1'b1, 1'b1, 32'hFFFF_FFFF, n, st);
    total++;
    if (n !== 2 || wif.rsp_status_o !== ST_ERR || wif.rsp_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL err_ack_same: cycles=%0d status=%0d dat=%h, required 2 1 0", n, wif.rsp_status_o, wif.rsp_dat_o);
    end
    tick();
    exp_q.push_back({ST_ERR, 32'h0});
    send_cmd(1'b1, 4'h1, 32'h3000_0020, 32'h0000_00AA, c);
    slave_reply(0, 1'b0, 1'b1, 32'h7777_7777, n, st);
    total++;
    if (n !== 1 || wif.rsp_status_o !== ST_ERR) begin
      bad++;
      $display("FAIL err_write: cycles=%0d status=%0d, required 1 1", n, wif.rsp_status_o);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    wif.wbm_ack_i = 1'b1;
    wif.wbm_dat_i = 32'hBAD0_BAD0;
    tick();
    wif.wbm_ack_i = 1'b0;
    wif.wbm_err_i = 1'b1;
    tick();
    wif.wbm_err_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wif.rsp_valid_o !== 1'b0 || wif.wbm_cyc_o !== 1'b0 || dbg_state !== IDLE || wif.cmd_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL stray_ack: valid=%b cyc=%b state=%0d ready=%b, required 0 0 0 1", wif.rsp_valid_o, wif.wbm_cyc_o, dbg_state, wif.cmd_ready_o);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int c;
    int n;
    logic st;
    exp_q.push_back({ST_TIMEOUT, 32'h0});
    send_cmd(1'b0, 4'hF, 32'h3000_0040, 32'h0, c);
    slave_reply(-1, 1'b0, 1'b0, 32'h0, n, st);
    total++;
    if (n !== TMO || st !== 1'b1 || wif.rsp_status_o !== ST_TIMEOUT || wif.rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_silent: cycles=%0d stable=%b status=%0d valid=%b, required %0d 1 2 1", n, st, wif.rsp_status_o, wif.rsp_valid_o, TMO);
    end
    tick();
    exp_q.push_back({ST_OK, 32'hCAFE_F00D});
    send_cmd(1'b0, 4'hF, 32'h3000_0044, 32'h0, c);
    slave_reply(TMO - 1, 1'b1, 1'b0, 32'hCAFE_F00D, n, st);
    total++;
    if (n !== TMO || wif.rsp_status_o !== ST_OK) begin
      bad++;
      $display("FAIL timeout_ack_last: cycles=%0d status=%0d, required %0d 0", n, wif.rsp_status_o, TMO);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    int n;
    logic st;
    exp_q.push_back({ST_OK, 32'h0});
    send_cmd(1'b1, 4'hF, 32'h3000_0100, 32'h0BAD_F00D, c0);
    slave_reply(0, 1'b1, 1'b0, 32'h0, n, st);
    exp_q.push_back({ST_OK, 32'h55AA_1234});
    send_cmd(1'b0, 4'hF, 32'h3000_0104, 32'h0, c1);
    total++;
    if (c1 - c0 !== 3) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles, required 3", c1 - c0);
    end
    slave_reply(0, 1'b1, 1'b0, 32'h55AA_1234, n, st);
    tick();
  endtask

  task automatic test_reset_mid();
    int c;
    int n;
    logic st;
    send_cmd(1'b1, 4'hF, 32'h3000_0200, 32'h1111_2222, c);
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (wif.wbm_cyc_o !== 1'b0 || wif.wbm_stb_o !== 1'b0 || wif.busy_o !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid_async: cyc=%b stb=%b busy=%b state=%0d, required 0 0 0 0", wif.wbm_cyc_o, wif.wbm_stb_o, wif.busy_o, dbg_state);
    end
    @(negedge clk);
    total++;
    if (wif.rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_rsp: valid=%b, required 0", wif.rsp_valid_o);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    exp_q.push_back({ST_OK, 32'h0});
    send_cmd(1'b1, 4'hC, 32'h3000_0204, 32'h3333_4444, c);
    slave_reply(1, 1'b1, 1'b0, 32'h0, n, st);
    total++;
    if (n !== 2 || wif.rsp_valid_o !== 1'b1 || wif.rsp_status_o !== ST_OK) begin
      bad++;
      $display("FAIL reset_mid_recover: cycles=%0d valid=%b status=%0d, required 2 1 0", n, wif.rsp_valid_o, wif.rsp_status_o);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_error();
    test_stray_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
